// File: rtl/wb_check_resp.sv
// wb_check_resp -- Wishbone slave holding the checkbit pad value and output
// enables, plus a scratch register and a count of CHECK writes.
//
// Parameters:
//   WAIT_CYC      wait states inserted before the response (0..15)
//
// Ports:
//   wb_clk_i      clock, all logic on the rising edge
//   wb_rst_n      synchronous active-low reset
//   wbs_cyc_i     bus cycle valid
//   wbs_stb_i     strobe
//   wbs_we_i      1 = write, 0 = read
//   wbs_adr_i     byte address, [4:2] selects the register, [1:0] ignored
//   wbs_sel_i     byte-lane enables
//   wbs_dat_i     write data
//   wbs_dat_o     read data, non-zero only during the ack cycle of a read
//   wbs_ack_o     transfer acknowledge
//   wbs_err_o     transfer error
//   check_o       checkbit value toward the pads
//   check_oeb_o   per-bit output enable, active-low
//
// Register map (word offsets):
//   0x00 CHECK    RW 16b   drives check_o
//   0x04 OEB      RW 16b   drives check_oeb_o
//   0x08 SCRATCH  RW 32b
//   0x0C WCOUNT   RO 16b   CHECK write count, any write clears it
//   0x10-0x1C     unmapped
//
// Build option:
//   WB_CHECK_RESP_ERR_EN  when defined, unmapped accesses finish with
//                         wbs_err_o instead of wbs_ack_o; otherwise
//                         wbs_err_o is tied low.
//
// FSM states:
//   state   | meaning
//   IDLE    | waiting for cyc&stb, request fields captured on acceptance
//   WAIT    | counting down wait states, cyc low aborts the transfer
//   RESP    | one-cycle ack/err, register write takes effect here

module wb_check_resp #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [4:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [15:0] check_o,
    output logic [15:0] check_oeb_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit         NO_WAIT  = (WAIT_CYC == 0);
    localparam logic [3:0] CNT_LOAD = 4'(NO_WAIT ? 0 : WAIT_CYC - 1);

    localparam logic [2:0] REG_CHECK   = 3'd0;
    localparam logic [2:0] REG_OEB     = 3'd1;
    localparam logic [2:0] REG_SCRATCH = 3'd2;
    localparam logic [2:0] REG_WCOUNT  = 3'd3;

    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [2:0]  adr_q,     adr_d;
    logic        we_q,      we_d;
    logic [3:0]  sel_q,     sel_d;
    logic [31:0] dat_q,     dat_d;
    logic [15:0] check_q,   check_d;
    logic [15:0] oeb_q,     oeb_d;
    logic [31:0] scratch_q, scratch_d;
    logic [15:0] wcount_q,  wcount_d;

    logic        resp;
    logic        unmapped;
    logic [31:0] rdata;

    // Byte-offset bits carry no meaning for word registers.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            check_q   <= 16'h0000;
            oeb_q     <= 16'hFFFF;
            scratch_q <= '0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            check_q   <= check_d;
            oeb_q     <= oeb_d;
            scratch_q <= scratch_d;
            wcount_q  <= wcount_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        check_d   = check_q;
        oeb_d     = oeb_q;
        scratch_d = scratch_q;
        wcount_d  = wcount_q;

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    adr_d   = wbs_adr_i[4:2];
                    we_d    = wbs_we_i;
                    sel_d   = wbs_sel_i;
                    dat_d   = wbs_dat_i;
                    cnt_d   = CNT_LOAD;
                    state_d = NO_WAIT ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Abort wins over the counter reaching zero.
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (we_q) begin
                    case (adr_q)
                        REG_CHECK: begin
                            for (int i = 0; i < 2; i++) begin
                                if (sel_q[i]) check_d[8*i +: 8] = dat_q[8*i +: 8];
                            end
                            if ((sel_q[0] || sel_q[1]) && (wcount_q != 16'hFFFF)) begin
                                wcount_d = wcount_q + 16'd1;
                            end
                        end
                        REG_OEB: begin
                            for (int i = 0; i < 2; i++) begin
                                if (sel_q[i]) oeb_d[8*i +: 8] = dat_q[8*i +: 8];
                            end
                        end
                        REG_SCRATCH: begin
                            for (int i = 0; i < 4; i++) begin
                                if (sel_q[i]) scratch_d[8*i +: 8] = dat_q[8*i +: 8];
                            end
                        end
                        REG_WCOUNT: begin
                            wcount_d = 16'h0000;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (adr_q)
            REG_CHECK:   rdata = {16'h0000, check_q};
            REG_OEB:     rdata = {16'h0000, oeb_q};
            REG_SCRATCH: rdata = scratch_q;
            REG_WCOUNT:  rdata = {16'h0000, wcount_q};
            default:     rdata = '0;
        endcase
    end

    assign resp     = (state_q == ST_RESP);
    assign unmapped = adr_q[2];

`ifdef WB_CHECK_RESP_ERR_EN
    assign wbs_ack_o = resp && !unmapped;
    assign wbs_err_o = resp && unmapped;
`else
    assign wbs_ack_o = resp;
    assign wbs_err_o = 1'b0;
`endif

    assign wbs_dat_o   = (resp && !we_q) ? rdata : 32'h0000_0000;
    assign check_o     = check_q;
    assign check_oeb_o = oeb_q;

endmodule
